// File: rtl/coredma_fifo_pkg.sv
// coredma_fifo_pkg: shared constants, pointer type and pointer arithmetic for the DMA micro-RAM FIFO
package coredma_fifo_pkg;
  localparam int DATA_WIDTH = 50;
  localparam int ADDR_WIDTH = 2;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int SKID_DEPTH = 3;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int LEVEL_W = ADDR_WIDTH + 2;
  typedef logic [ADDR_WIDTH:0] ptr_t;
  function automatic ptr_t ptr_diff(ptr_t a, ptr_t b);
    return a - b;
  endfunction
endpackage

// File: rtl/coredma_skid_fifo.sv
// coredma_skid_fifo: shift-register FIFO whose head entry drives the stream straight from flops
module coredma_skid_fifo
  import coredma_fifo_pkg::*;
#(
  parameter int W = DATA_WIDTH,
  parameter int D = SKID_DEPTH,
  parameter int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic          head_valid,
  output logic [CW-1:0] cnt
);
  logic [W-1:0] mem [D];
  logic [CW-1:0] wr_idx;
  assign wr_idx = cnt - CW'(pop);
  assign head = mem[0];
  assign head_valid = cnt != '0;
  always_ff @(posedge clk)
    if (rst || flush) begin
      cnt <= '0;
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < D; i++)
        mem[i] <= (push && CW'(i) == wr_idx) ? din : (pop && i < D - 1) ? mem[(i + 1) % D] : mem[i];
      cnt <= cnt + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/coredma_sram_fifo_rd_ctrl.sv
// coredma_sram_fifo_rd_ctrl: prefetches micro-RAM words (latency 2) into a skid FIFO and streams them out
module coredma_sram_fifo_rd_ctrl
  import coredma_fifo_pkg::*;
(
  input  logic                  CLK,
  input  logic                  SRST_N,
  input  logic                  FLUSH,
  input  logic [ADDR_WIDTH:0]   WR_PTR,
  output logic [ADDR_WIDTH:0]   RD_PTR,
  output logic [ADDR_WIDTH-1:0] RAM_R_ADDR,
  output logic                  RAM_R_ADDR_EN,
  output logic                  RAM_R_DATA_EN,
  input  logic [DATA_WIDTH-1:0] RAM_R_DATA,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DOUT_VALID,
  input  logic                  DOUT_READY,
  output logic [LEVEL_W-1:0]    LEVEL
);
  localparam int OCC_W = SKID_CNT_W + 1;
  ptr_t iss_ptr;
  logic s1, s2, pop, issue;
  logic [SKID_CNT_W-1:0] skid_cnt;
  logic [OCC_W-1:0] occ;
  always_comb begin
    pop = DOUT_VALID & DOUT_READY;
    occ = OCC_W'(skid_cnt) + OCC_W'(s1) + OCC_W'(s2) - OCC_W'(pop);
    issue = SRST_N & ~FLUSH & (iss_ptr != WR_PTR) & (occ < OCC_W'(SKID_DEPTH));
    RAM_R_ADDR_EN = issue;
    RAM_R_ADDR = iss_ptr[ADDR_WIDTH-1:0];
    RAM_R_DATA_EN = s1;
    LEVEL = SRST_N ? LEVEL_W'(ptr_diff(WR_PTR, RD_PTR)) + LEVEL_W'(skid_cnt) : '0;
  end
  always_ff @(posedge CLK)
    if (!SRST_N) begin
      iss_ptr <= '0;
      RD_PTR <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (FLUSH) begin
      iss_ptr <= WR_PTR;
      RD_PTR <= WR_PTR;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      iss_ptr <= iss_ptr + ptr_t'(issue);
      RD_PTR <= RD_PTR + ptr_t'(s2);
      s1 <= issue;
      s2 <= s1;
    end
  coredma_skid_fifo u_skid (
    .clk       (CLK),
    .rst       (!SRST_N),
    .flush     (FLUSH),
    .push      (s2),
    .pop       (pop),
    .din       (RAM_R_DATA),
    .head      (DOUT),
    .head_valid(DOUT_VALID),
    .cnt       (skid_cnt)
  );
endmodule

// File: tb/tb_coredma_sram_fifo_rd_ctrl.sv
// tb_coredma_sram_fifo_rd_ctrl: directed vector table plus multi-cycle sequences against a latency-2 RAM model
module tb_coredma_sram_fifo_rd_ctrl;
  import coredma_fifo_pkg::*;
  localparam logic [DATA_WIDTH-1:0] A0 = 50'h0_1111_2222_3333;
  localparam logic [DATA_WIDTH-1:0] A1 = 50'h1_4444_5555_6666;
  localparam logic [DATA_WIDTH-1:0] A2 = 50'h3_7777_8888_9999;
  localparam logic [DATA_WIDTH-1:0] PAT = 50'h2_AAAA_5555_1234;
  localparam logic [DATA_WIDTH-1:0] Z = '0;
  typedef struct {
    logic rst_n;
    logic flush;
    logic [ADDR_WIDTH:0] wr;
    logic ready;
    logic exp_aen;
    logic exp_den;
    logic exp_v;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic [DATA_WIDTH-1:0] exp_dout;
    logic [ADDR_WIDTH:0] exp_rd;
    logic [LEVEL_W-1:0] exp_lvl;
  } vec_t;
  logic clk = 1'b0;
  logic srst_n, flush, ready;
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] ram_r_addr;
  logic ram_r_addr_en, ram_r_data_en, dout_valid;
  logic [DATA_WIDTH-1:0] ram_q, dout;
  logic [LEVEL_W-1:0] level;
  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [ADDR_WIDTH-1:0] ram_a;
  int n_vec = 0;
  int n_err = 0;
  vec_t tv [13];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_r_addr_en) ram_a <= ram_r_addr;
    if (ram_r_data_en) ram_q <= ram[ram_a];
  end
  coredma_sram_fifo_rd_ctrl dut (
    .CLK          (clk),
    .SRST_N       (srst_n),
    .FLUSH        (flush),
    .WR_PTR       (wr_ptr),
    .RD_PTR       (rd_ptr),
    .RAM_R_ADDR   (ram_r_addr),
    .RAM_R_ADDR_EN(ram_r_addr_en),
    .RAM_R_DATA_EN(ram_r_data_en),
    .RAM_R_DATA   (ram_q),
    .DOUT         (dout),
    .DOUT_VALID   (dout_valid),
    .DOUT_READY   (ready),
    .LEVEL        (level)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [DATA_WIDTH-1:0] w;
    logic [DATA_WIDTH-1:0] exp_q [$];
    int got, first, last, wrote, issues, stale;
    bit saw7, wrapped;
    tv[0]  = '{1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, Z,   3'd0, 4'd0};
    tv[1]  = '{1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, Z,   3'd0, 4'd0};
    tv[2]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, Z,   3'd0, 4'd3};
    tv[3]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, Z,   3'd0, 4'd3};
    tv[4]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, Z,   3'd0, 4'd3};
    tv[5]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, A0,  3'd1, 4'd3};
    tv[6]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, A1,  3'd2, 4'd2};
    tv[7]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, A2,  3'd3, 4'd1};
    tv[8]  = '{1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, Z,   3'd3, 4'd1};
    tv[9]  = '{1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, Z,   3'd3, 4'd1};
    tv[10] = '{1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, Z,   3'd3, 4'd1};
    tv[11] = '{1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, PAT, 3'd4, 4'd1};
    tv[12] = '{1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, Z,   3'd4, 4'd0};
    ram[0] = A0;
    ram[1] = A1;
    ram[2] = A2;
    ram[3] = PAT;
    srst_n = 1'b0;
    flush = 1'b0;
    wr_ptr = 3'd3;
    ready = 1'b1;
    tick;
    for (int i = 0; i < 13; i++) begin
      srst_n = tv[i].rst_n;
      flush = tv[i].flush;
      wr_ptr = tv[i].wr;
      ready = tv[i].ready;
      #1;
      chk($sformatf("v%0d_addr_en", i), ram_r_addr_en, tv[i].exp_aen);
      chk($sformatf("v%0d_data_en", i), ram_r_data_en, tv[i].exp_den);
      chk($sformatf("v%0d_valid", i), dout_valid, tv[i].exp_v);
      chk($sformatf("v%0d_rd_ptr", i), rd_ptr, tv[i].exp_rd);
      chk($sformatf("v%0d_level", i), level, tv[i].exp_lvl);
      if (tv[i].exp_aen) chk($sformatf("v%0d_addr", i), ram_r_addr, tv[i].exp_addr);
      if (tv[i].exp_v || !tv[i].rst_n) chk($sformatf("v%0d_dout", i), dout, tv[i].exp_dout);
      tick;
    end
    got = 0; first = -1; last = -1; wrote = 0; saw7 = 0; wrapped = 0;
    for (int c = 0; c < 40; c++) begin
      if (wrote < 10 && ptr_diff(wr_ptr, rd_ptr) < 3'(DEPTH)) begin
        w = {26'h2ABCDEF, 24'(wrote)};
        ram[wr_ptr[ADDR_WIDTH-1:0]] = w;
        exp_q.push_back(w);
        wr_ptr = wr_ptr + 3'd1;
        wrote++;
      end
      #1;
      if (dout_valid) begin
        if (exp_q.size() == 0) chk("burst_extra_word", dout, 64'hDEAD);
        else chk($sformatf("burst_word%0d", got), dout, exp_q.pop_front());
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (rd_ptr == 3'd7) saw7 = 1;
      if (saw7 && rd_ptr == 3'd0) wrapped = 1;
      tick;
    end
    chk("burst_count", got, 10);
    chk("burst_consecutive", last - first, 9);
    chk("burst_rd_ptr_wrap", wrapped, 1);
    chk("burst_rd_ptr_end", rd_ptr, 3'd6);
    chk("burst_level_end", level, 4'd0);
    ready = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      w = {26'h1234567, 24'(k + 100)};
      ram[(6 + k) % DEPTH] = w;
      exp_q.push_back(w);
    end
    wr_ptr = 3'd2;
    issues = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (ram_r_addr_en) issues++;
      if (c >= 3) chk($sformatf("bp_hold%0d", c), {dout_valid, dout}, {1'b1, exp_q[0]});
      tick;
    end
    chk("bp_issues", issues, 3);
    chk("bp_skid_cnt", dut.skid_cnt, 2'd3);
    chk("bp_rd_ptr", rd_ptr, 3'd1);
    chk("bp_level", level, 4'd4);
    ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (dout_valid) begin
        if (exp_q.size() == 0) chk("bp_extra_word", dout, 64'hDEAD);
        else chk($sformatf("bp_pop%0d", got), dout, exp_q.pop_front());
        got++;
      end
      tick;
    end
    chk("bp_pop_count", got, 4);
    chk("bp_rd_ptr_end", rd_ptr, 3'd2);
    chk("bp_level_end", level, 4'd0);
    ready = 1'b0;
    ram[2] = 50'h0_F0F0_0000_0001;
    ram[3] = 50'h0_F0F0_0000_0002;
    ram[0] = 50'h0_F0F0_0000_0003;
    wr_ptr = 3'd5;
    tick;
    tick;
    tick;
    chk("fl_pre_s1", dut.s1, 1'b1);
    chk("fl_pre_s2", dut.s2, 1'b1);
    chk("fl_pre_skid", dut.skid_cnt, 2'd1);
    flush = 1'b1;
    ready = 1'b1;
    tick;
    flush = 1'b0;
    #1;
    chk("fl_valid", dout_valid, 1'b0);
    chk("fl_rd_ptr", rd_ptr, 3'd5);
    chk("fl_level", level, 4'd0);
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      if (dout_valid) stale++;
      tick;
      #1;
    end
    chk("fl_no_stale", stale, 0);
    ram[1] = 50'h0_EEEE_0000_0001;
    ram[2] = 50'h0_EEEE_0000_0002;
    wr_ptr = 3'd7;
    tick;
    tick;
    srst_n = 1'b0;
    #1;
    chk("rst_pre_s2", dut.s2, 1'b1);
    tick;
    wr_ptr = 3'd0;
    #1;
    chk("rst_rd_ptr", rd_ptr, 3'd0);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_skid", dut.skid_cnt, 2'd0);
    chk("rst_dout", dout, Z);
    chk("rst_level", level, 4'd0);
    tick;
    srst_n = 1'b1;
    ram[0] = 50'h1_CAFE_BABE_0042;
    wr_ptr = 3'd1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (dout_valid) begin
        chk($sformatf("rst_after_word%0d", got), dout, 50'h1_CAFE_BABE_0042);
        got++;
      end
      tick;
    end
    chk("rst_after_count", got, 1);
    chk("rst_after_rd_ptr", rd_ptr, 3'd1);
    chk("rst_after_level", level, 4'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
